ram_parity_scrubber: RTL and testbench

- Bus initiator that walks a parity-protected RAM port in the background, one word per scrub step.
- For each word it reads data plus the stored parity bit, recomputes even parity (XOR-reduce of the data) and compares.
- Mismatches are logged (first/last address, count) and raise a sticky interrupt.
- Sits on the second port of the dual-port data RAM. Yields to the core whenever the port is in use.

---
 rtl/ram_parity_scrubber_if.sv | 24 ++
 rtl/ram_parity_scrubber.sv | 183 ++++++++++++++++++
 tb/tb_ram_parity_scrubber.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_parity_scrubber_if.sv
// RAM port bundle between the parity scrubber (master) and the
// second port of the dual-port data RAM (slave).
interface ram_parity_scrubber_if #(
   parameter int unsigned dat_width = 32,
   parameter int unsigned adr_width = 32
) ();
   logic [adr_width-1:0] ram_adr_o;
   logic                 ram_re_o;
   logic                 ram_we_o;
   logic [dat_width-1:0] ram_dat_o;
   logic [dat_width-1:0] ram_dat_i;
   logic                 ram_par_i;
   logic                 port_busy_i;

   modport master (
      output ram_adr_o, ram_re_o, ram_we_o, ram_dat_o,
      input  ram_dat_i, ram_par_i, port_busy_i
   );

   modport slave (
      input  ram_adr_o, ram_re_o, ram_we_o, ram_dat_o,
      output ram_dat_i, ram_par_i, port_busy_i
   );
endinterface

// File: rtl/ram_parity_scrubber.sv
// Background even-parity scrubber for a RAM port: reads one word per step, logs mismatches.
// Optional write-back of mismatching words is enabled by defining SCRUB_WRITEBACK_EN.
module ram_parity_scrubber #(
   parameter int unsigned dat_width = 32,
   parameter int unsigned adr_width = 32,
   parameter int unsigned mem_size  = 1024,
   parameter int unsigned interval  = 16,
   parameter int unsigned cnt_width = 16
) (
   input  logic                 clk,
   input  logic                 rst_n_i,
   input  logic                 start_i,
   input  logic                 continuous_i,
   input  logic                 abort_i,
   ram_parity_scrubber_if.master bus,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [cnt_width-1:0] err_cnt_o,
   output logic [adr_width-1:0] first_err_adr_o,
   output logic [adr_width-1:0] last_err_adr_o,
   output logic                 irq_o,
   input  logic                 irq_clr_i
);

   localparam int unsigned gap_width = (interval > 1) ? $clog2(interval) : 1;
   localparam logic [adr_width-1:0] last_adr = adr_width'(mem_size - 1);
   localparam logic [cnt_width-1:0] cnt_max  = '1;

`ifdef SCRUB_WRITEBACK_EN
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, GAP, WB} state_t;
`else
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, GAP} state_t;
`endif

   state_t               state;
   logic [adr_width-1:0] ptr;
   logic [gap_width-1:0] gap_cnt;
   logic [adr_width-1:0] adr_q;
   logic                 re_q;
   logic                 we_q;
   logic [dat_width-1:0] dat_q;
   logic                 mismatch_c;
   logic                 gap_last_c;
   logic                 wb_need_c;
   logic                 advance_c;

   assign bus.ram_adr_o = adr_q;
   assign bus.ram_re_o  = re_q;
   assign bus.ram_we_o  = we_q;
   assign bus.ram_dat_o = dat_q;

   always_comb begin
      mismatch_c = ((^bus.ram_dat_i) != bus.ram_par_i);
      gap_last_c = (gap_cnt == gap_width'(interval - 1));
`ifdef SCRUB_WRITEBACK_EN
      wb_need_c  = mismatch_c;
`else
      wb_need_c  = 1'b0;
`endif
   end

   // End of a scrub step: the point where the pointer advances or the pass ends.
   always_comb begin
      advance_c = 1'b0;
      case (state)
         CHECK:   advance_c = (interval == 0) && !wb_need_c;
         GAP:     advance_c = !abort_i && gap_last_c;
`ifdef SCRUB_WRITEBACK_EN
         WB:      advance_c = (interval == 0) && !bus.port_busy_i;
`endif
         default: advance_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         state           <= IDLE;
         ptr             <= '0;
         gap_cnt         <= '0;
         adr_q           <= '0;
         re_q            <= 1'b0;
         we_q            <= 1'b0;
         dat_q           <= '0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         err_cnt_o       <= '0;
         first_err_adr_o <= '0;
         last_err_adr_o  <= '0;
         irq_o           <= 1'b0;
      end else begin
         re_q   <= 1'b0;
         we_q   <= 1'b0;
         done_o <= 1'b0;

         // Error log; a mismatch in the same cycle as a clear wins over the clear.
         if (irq_clr_i) begin
            err_cnt_o       <= '0;
            first_err_adr_o <= '0;
            last_err_adr_o  <= '0;
            irq_o           <= 1'b0;
         end
         if (state == CHECK && mismatch_c) begin
            if (irq_clr_i || err_cnt_o == '0) first_err_adr_o <= ptr;
            if (irq_clr_i)
               err_cnt_o <= cnt_width'(1);
            else if (err_cnt_o != cnt_max)
               err_cnt_o <= err_cnt_o + cnt_width'(1);
            last_err_adr_o <= ptr;
            irq_o          <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start_i) begin
                  state  <= ISSUE;
                  ptr    <= '0;
                  busy_o <= 1'b1;
               end
            end
            ISSUE: begin
               if (abort_i) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else if (!bus.port_busy_i) begin
                  re_q  <= 1'b1;
                  adr_q <= ptr;
                  state <= WAIT;
               end
            end
            WAIT: state <= CHECK;
            CHECK: begin
               gap_cnt <= '0;
               state   <= GAP;
`ifdef SCRUB_WRITEBACK_EN
               if (mismatch_c) begin
                  dat_q <= bus.ram_dat_i;
                  state <= WB;
               end
`endif
            end
            GAP: begin
               if (abort_i) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + gap_width'(1);
               end
            end
`ifdef SCRUB_WRITEBACK_EN
            WB: begin
               if (!bus.port_busy_i) begin
                  we_q    <= 1'b1;
                  adr_q   <= ptr;
                  gap_cnt <= '0;
                  state   <= GAP;
               end
            end
`endif
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase

         if (advance_c) begin
            if (ptr == last_adr) begin
               done_o <= 1'b1;
               if (continuous_i) begin
                  ptr   <= '0;
                  state <= ISSUE;
               end else begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end else begin
               ptr   <= ptr + adr_width'(1);
               state <= ISSUE;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_parity_scrubber.sv
// Directed bench for ram_parity_scrubber: one instance with a fast 8-word scan,
// one with a 4-word continuous scan and a 2-cycle gap.
module tb_ram_parity_scrubber;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Instance a: 8 words, no gap, 2-bit counter so saturation is reachable.
   ram_parity_scrubber_if #(.dat_width(32), .adr_width(32)) bus_a ();
   logic        start_a, cont_a, abort_a, clr_a;
   logic        busy_a, done_a, irq_a;
   logic [1:0]  err_a;
   logic [31:0] first_a, last_a;

   ram_parity_scrubber #(
      .dat_width(32), .adr_width(32), .mem_size(8), .interval(0), .cnt_width(2)
   ) u_a (
      .clk(clk), .rst_n_i(rst_n), .start_i(start_a), .continuous_i(cont_a),
      .abort_i(abort_a), .bus(bus_a), .busy_o(busy_a), .done_o(done_a),
      .err_cnt_o(err_a), .first_err_adr_o(first_a), .last_err_adr_o(last_a),
      .irq_o(irq_a), .irq_clr_i(clr_a)
   );

   // Instance b: 4 words, 2 idle cycles per step.
   ram_parity_scrubber_if #(.dat_width(32), .adr_width(32)) bus_b ();
   logic        start_b, cont_b, abort_b, clr_b;
   logic        busy_b, done_b, irq_b;
   logic [15:0] err_b;
   logic [31:0] first_b, last_b;

   ram_parity_scrubber #(
      .dat_width(32), .adr_width(32), .mem_size(4), .interval(2), .cnt_width(16)
   ) u_b (
      .clk(clk), .rst_n_i(rst_n), .start_i(start_b), .continuous_i(cont_b),
      .abort_i(abort_b), .bus(bus_b), .busy_o(busy_b), .done_o(done_b),
      .err_cnt_o(err_b), .first_err_adr_o(first_b), .last_err_adr_o(last_b),
      .irq_o(irq_b), .irq_clr_i(clr_b)
   );

   // RAM models: registered read, parity regenerated on write.
   logic [31:0] mem_a [8];
   logic        par_a [8];
   logic [31:0] mem_b [4];
   logic        par_b [4];

   always @(posedge clk) begin
      if (bus_a.ram_re_o) begin
         bus_a.ram_dat_i <= mem_a[bus_a.ram_adr_o[2:0]];
         bus_a.ram_par_i <= par_a[bus_a.ram_adr_o[2:0]];
      end
      if (bus_a.ram_we_o) begin
         mem_a[bus_a.ram_adr_o[2:0]] = bus_a.ram_dat_o;
         par_a[bus_a.ram_adr_o[2:0]] = ^bus_a.ram_dat_o;
      end
      if (bus_b.ram_re_o) begin
         bus_b.ram_dat_i <= mem_b[bus_b.ram_adr_o[1:0]];
         bus_b.ram_par_i <= par_b[bus_b.ram_adr_o[1:0]];
      end
   end

   // Monitors sample mid-cycle, away from the active edge.
   logic [31:0] rd_adr_a [$];
   int          rd_cyc_a [$];
   logic [31:0] rd_adr_b [$];
   int          rd_cyc_b [$];
   int          ndone_a = 0, ndone_b = 0, nwe_a = 0;
   logic [31:0] we_adr_a, we_dat_a;

   always @(negedge clk) begin
      if (bus_a.ram_re_o) begin
         rd_adr_a.push_back(bus_a.ram_adr_o);
         rd_cyc_a.push_back(cyc);
      end
      if (bus_b.ram_re_o) begin
         rd_adr_b.push_back(bus_b.ram_adr_o);
         rd_cyc_b.push_back(cyc);
      end
      if (done_a) ndone_a++;
      if (done_b) ndone_b++;
      if (bus_a.ram_we_o) begin
         nwe_a++;
         we_adr_a = bus_a.ram_adr_o;
         we_dat_a = bus_a.ram_dat_o;
      end
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse_start_a();
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string tag);
      int base = ndone_a;
      int k = 0;
      while (ndone_a == base && k < 300) begin
         tick(1);
         k++;
      end
      check(tag, 64'(ndone_a > base), 64'd1);
      tick(2);
   endtask

   task automatic fix_parity_a();
      for (int i = 0; i < 8; i++) par_a[i] = ^mem_a[i];
   endtask

   function automatic logic seq_ok_a();
      logic ok = (rd_adr_a.size() == 8);
      if (ok)
         for (int i = 0; i < 8; i++)
            if (rd_adr_a[i] != 32'(i)) ok = 1'b0;
      return ok;
   endfunction

   initial begin
      int k, s, d;
      logic ok;

      rst_n = 1'b0;
      {start_a, cont_a, abort_a, clr_a} = '0;
      {start_b, cont_b, abort_b, clr_b} = '0;
      bus_a.port_busy_i = 1'b0; bus_a.ram_dat_i = '0; bus_a.ram_par_i = 1'b0;
      bus_b.port_busy_i = 1'b0; bus_b.ram_dat_i = '0; bus_b.ram_par_i = 1'b0;
      for (int i = 0; i < 8; i++) mem_a[i] = 32'hA5C3_0000 + 32'(i) * 32'h0001_1357;
      for (int i = 0; i < 4; i++) mem_b[i] = 32'h0F0F_1000 + 32'(i) * 32'h0000_0301;
      fix_parity_a();
      for (int i = 0; i < 4; i++) par_b[i] = ^mem_b[i];
      tick(3);

      // Reset state
      check("rst_busy", 64'(busy_a), 64'd0);
      check("rst_done", 64'(done_a), 64'd0);
      check("rst_re",   64'(bus_a.ram_re_o), 64'd0);
      check("rst_we",   64'(bus_a.ram_we_o), 64'd0);
      check("rst_adr",  64'(bus_a.ram_adr_o), 64'd0);
      check("rst_dat",  64'(bus_a.ram_dat_o), 64'd0);
      check("rst_err",  64'(err_a), 64'd0);
      check("rst_first", 64'(first_a), 64'd0);
      check("rst_last", 64'(last_a), 64'd0);
      check("rst_irq",  64'(irq_a), 64'd0);
      rst_n = 1'b1;
      tick(2);

      // Clean pass; a second start mid-pass must be ignored.
      rd_adr_a.delete(); rd_cyc_a.delete();
      pulse_start_a();
      check("t1_busy", 64'(busy_a), 64'd1);
      tick(5);
      pulse_start_a();
      wait_done_a("t1_done_timeout");
      check("t1_seq", 64'(seq_ok_a()), 64'd1);
      check("t1_step3", 64'(rd_cyc_a.size() == 8 ? rd_cyc_a[7] - rd_cyc_a[0] : -1), 64'd21);
      check("t1_ndone", 64'(ndone_a), 64'd1);
      check("t1_err", 64'(err_a), 64'd0);
      check("t1_irq", 64'(irq_a), 64'd0);
      check("t1_busy_end", 64'(busy_a), 64'd0);

      // Corrupted parity at words 3 and 6, then clear.
      par_a[3] = ~par_a[3];
      par_a[6] = ~par_a[6];
      pulse_start_a();
      wait_done_a("t2_done_timeout");
      check("t2_err", 64'(err_a), 64'd2);
      check("t2_first", 64'(first_a), 64'd3);
      check("t2_last", 64'(last_a), 64'd6);
      check("t2_irq", 64'(irq_a), 64'd1);
      clr_a = 1'b1; tick(1); clr_a = 1'b0;
      check("t2_clr_err", 64'(err_a), 64'd0);
      check("t2_clr_first", 64'(first_a), 64'd0);
      check("t2_clr_last", 64'(last_a), 64'd0);
      check("t2_clr_irq", 64'(irq_a), 64'd0);
      fix_parity_a();

      // Five errors into a 2-bit counter: saturates at 3.
      foreach (par_a[i]) if (i <= 3 || i == 7) par_a[i] = ~par_a[i];
      pulse_start_a();
      wait_done_a("t4_done_timeout");
      check("t4_err_sat", 64'(err_a), 64'd3);
      check("t4_first", 64'(first_a), 64'd0);
      check("t4_last", 64'(last_a), 64'd7);
      clr_a = 1'b1; tick(1); clr_a = 1'b0;
      fix_parity_a();

      // Port held busy while the scrubber waits to issue address 2.
      rd_adr_a.delete(); rd_cyc_a.delete();
      pulse_start_a();
      k = 0;
      while (rd_adr_a.size() < 2 && k < 50) begin tick(1); k++; end
      check("t3_reach_timeout", 64'(rd_adr_a.size() >= 2), 64'd1);
      bus_a.port_busy_i = 1'b1;
      s = rd_adr_a.size();
      tick(7);
      check("t3_no_issue", 64'(rd_adr_a.size()), 64'(s));
      bus_a.port_busy_i = 1'b0;
      wait_done_a("t3_done_timeout");
      check("t3_seq", 64'(seq_ok_a()), 64'd1);
      check("t3_stall", 64'(rd_cyc_a.size() == 8 ? rd_cyc_a[2] - rd_cyc_a[1] : -1), 64'd8);

      // Mismatch at address 5 in the same cycle as a clear.
      par_a[3] = ~par_a[3];
      par_a[5] = ~par_a[5];
      rd_adr_a.delete(); rd_cyc_a.delete();
      pulse_start_a();
      k = 0;
      while (rd_adr_a.size() < 6 && k < 50) begin tick(1); k++; end
      check("t5_reach_timeout", 64'(rd_adr_a.size() >= 6), 64'd1);
      check("t5_pre_err", 64'(err_a), 64'd1);
      tick(1);
      clr_a = 1'b1; tick(1); clr_a = 1'b0;
      check("t5_irq", 64'(irq_a), 64'd1);
      check("t5_err", 64'(err_a), 64'd1);
      check("t5_first", 64'(first_a), 64'd5);
      check("t5_last", 64'(last_a), 64'd5);
      wait_done_a("t5_done_timeout");
      clr_a = 1'b1; tick(1); clr_a = 1'b0;
      fix_parity_a();

`ifdef SCRUB_WRITEBACK_EN
      // Write-back repairs word 4; a second pass sees no new error.
      par_a[4] = ~par_a[4];
      d = nwe_a;
      pulse_start_a();
      wait_done_a("t6_done_timeout");
      check("t6_nwe", 64'(nwe_a - d), 64'd1);
      check("t6_we_adr", 64'(we_adr_a), 64'd4);
      check("t6_we_dat", 64'(we_dat_a), 64'(mem_a[4]));
      check("t6_err", 64'(err_a), 64'd1);
      pulse_start_a();
      wait_done_a("t6_done2_timeout");
      check("t6_err_again", 64'(err_a), 64'd1);
      check("t6_nwe_again", 64'(nwe_a - d), 64'd1);
      clr_a = 1'b1; tick(1); clr_a = 1'b0;
`else
      check("t6_no_write", 64'(nwe_a), 64'd0);
`endif

      // Continuous scan with gap, then abort mid-pass.
      cont_b = 1'b1;
      start_b = 1'b1; tick(1); start_b = 1'b0;
      k = 0;
      while (ndone_b < 2 && k < 200) begin tick(1); k++; end
      check("b_done_timeout", 64'(ndone_b >= 2), 64'd1);
      ok = (rd_adr_b.size() >= 8);
      if (ok)
         for (int i = 0; i < 8; i++)
            if (rd_adr_b[i] != 32'(i % 4)) ok = 1'b0;
      check("b_wrap_seq", 64'(ok), 64'd1);
      check("b_step5", 64'(rd_cyc_b.size() >= 5 ? rd_cyc_b[4] - rd_cyc_b[3] : -1), 64'd5);
      s = rd_adr_b.size();
      k = 0;
      while (!(rd_adr_b.size() > s && rd_adr_b[rd_adr_b.size()-1] == 32'd1) && k < 50) begin
         tick(1);
         k++;
      end
      check("b_reach_timeout", 64'(rd_adr_b.size() > s), 64'd1);
      abort_b = 1'b1;
      d = ndone_b;
      s = rd_adr_b.size();
      k = 0;
      while (busy_b && k < 20) begin tick(1); k++; end
      abort_b = 1'b0;
      check("b_abort_busy", 64'(busy_b), 64'd0);
      tick(20);
      check("b_abort_nodone", 64'(ndone_b), 64'(d));
      check("b_abort_noread", 64'(rd_adr_b.size()), 64'(s));
      check("b_err", 64'(err_b), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
